// File: rtl/video_pkg.sv
// Constants shared by the video path (sync generator, frame-buffer arbiter).
// Also holds the arbiter state encoding.
package video_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    HOST = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_rd_ptr.sv
// Linear display read pointer: wraps at the end of the frame buffer and is rewound
// to 0 on frame start, never while a burst is still issuing reads.
module vram_rd_ptr #(
  parameter int FB_WORDS = video_pkg::FB_WORDS,
  parameter int ADDR_W   = video_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              frame_start,
  input  logic              burst_end,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic              rewind_pend_reg;
  logic              rewind_now;
  logic [ADDR_W-1:0] ptr_next;

  // A pending rewind lands on the first edge that is not advancing the pointer
  // mid-burst, so reads already committed to a burst keep their addresses.
  assign rewind_now = (frame_start || rewind_pend_reg) && (burst_end || !inc);
  assign ptr_next   = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      rewind_pend_reg <= 1'b0;
    end else if (rewind_now) begin
      ptr             <= '0;
      rewind_pend_reg <= 1'b0;
    end else begin
      if (inc) begin
        ptr <= ptr_next;
      end
      if (frame_start) begin
        rewind_pend_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port frame-buffer RAM between fixed-length display read bursts
// and single-word host writes; a waiting host is served after at most one burst.
module vram_arbiter #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int ADDR_W   = video_pkg::ADDR_W,
  parameter int DATA_W   = video_pkg::DATA_W,
  parameter int BURST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              disp_req,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_wr_req,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import video_pkg::*;

  localparam int               FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int               CNT_W       = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BURST - 1);

  arb_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              host_owed_reg;
  logic              rd_pend_reg;
  logic [ADDR_W-1:0] rd_ptr;
  logic              last_read;
  logic              grant_host;
  logic              grant_disp;
  logic              ptr_inc;

  // cnt_reg tracks the read currently on the RAM pins; the last one ends the burst.
  assign last_read  = (state_reg == DISP) && (cnt_reg == LAST_CNT);
  assign grant_host = (state_reg == IDLE) && host_wr_req && (!disp_req || host_owed_reg);
  assign grant_disp = (state_reg == IDLE) && disp_req && !grant_host;
  assign ptr_inc    = grant_disp || ((state_reg == DISP) && !last_read);

  vram_rd_ptr #(
    .FB_WORDS (FRAME_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_rd_ptr (
    .clk         (clk),
    .rst         (rst),
    .inc         (ptr_inc),
    .frame_start (frame_start),
    .burst_end   (last_read),
    .ptr         (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      host_owed_reg <= 1'b0;
      rd_pend_reg   <= 1'b0;
      disp_rvalid   <= 1'b0;
      disp_rdata    <= '0;
      host_wr_ack   <= 1'b0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      // Read return path: one cycle inside the RAM, one in this register stage.
      rd_pend_reg <= ram_en && !ram_we;
      disp_rvalid <= rd_pend_reg;
      if (rd_pend_reg) begin
        disp_rdata <= ram_rdata;
      end

      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      host_wr_ack <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (grant_host) begin
            state_reg     <= HOST;
            ram_en        <= 1'b1;
            ram_we        <= 1'b1;
            ram_addr      <= host_wr_addr;
            ram_wdata     <= host_wr_data;
            host_wr_ack   <= 1'b1;
            host_owed_reg <= 1'b0;
          end else if (grant_disp) begin
            state_reg <= DISP;
            ram_en    <= 1'b1;
            ram_addr  <= rd_ptr;
            cnt_reg   <= '0;
          end
        end
        DISP: begin
          if (last_read) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            if (host_wr_req) begin
              host_owed_reg <= 1'b1;
            end
          end else begin
            ram_en   <= 1'b1;
            ram_addr <= rd_ptr;
            cnt_reg  <= cnt_reg + 1'b1;
          end
        end
        HOST: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small 24x17 frame so that pointer wrap
// is reachable in a few hundred cycles; the RAM model holds a known address pattern.
module tb_vram_arbiter;

  localparam int H_ACTIVE = 24;
  localparam int V_ACTIVE = 17;
  localparam int FBW      = H_ACTIVE * V_ACTIVE;  // 408 words
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int BURST    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              disp_req = 1'b0;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              host_wr_req = 1'b0;
  logic [ADDR_W-1:0] host_wr_addr = '0;
  logic [DATA_W-1:0] host_wr_data = '0;
  logic              host_wr_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic [DATA_W-1:0] mem [0:8191];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BURST    (BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .disp_req     (disp_req),
    .disp_rvalid  (disp_rvalid),
    .disp_rdata   (disp_rdata),
    .host_wr_req  (host_wr_req),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_ack  (host_wr_ack),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'(a * 7 + 3);
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[12:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[12:0]];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ram_en, ram_we, host_wr_ack, disp_rvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl en/we/ack/rvalid=%b want 0000", {ram_en, ram_we, host_wr_ack, disp_rvalid});
    end
    checks++;
    if (ram_addr !== '0 || ram_wdata !== '0 || disp_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%0h wdata=%0h rdata=%0h want 0", ram_addr, ram_wdata, disp_rdata);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ram_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ram_en=%b want 0", ram_en);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_disp;
    int nvalid;
    nvalid = 0;
    disp_req = 1'b1;
    checks++;
    if (ram_en !== 1'b0) begin
      errors++;
      $display("FAIL single_decision ram_en=%b want 0", ram_en);
    end
    for (int i = 0; i < BURST; i++) begin
      tick();
      if (i == 0) disp_req = 1'b0;
      if (disp_rvalid === 1'b1) nvalid++;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL single_rd[%0d] en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", i, ram_en, ram_we, ram_addr, i);
      end
      checks++;
      if (i >= 2) begin
        if (disp_rvalid !== 1'b1 || disp_rdata !== pat(i - 2)) begin
          errors++;
          $display("FAIL single_rv[%0d] rvalid=%b data=%0h want 1/%0h", i, disp_rvalid, disp_rdata, pat(i - 2));
        end
      end else if (disp_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL single_rv_early[%0d] rvalid=%b want 0", i, disp_rvalid);
      end
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (disp_rvalid === 1'b1) nvalid++;
      checks++;
      if (j < 2) begin
        if (ram_en !== 1'b0 || disp_rvalid !== 1'b1 || disp_rdata !== pat(14 + j)) begin
          errors++;
          $display("FAIL single_tail[%0d] en=%b rvalid=%b data=%0h want 0/1/%0h", j, ram_en, disp_rvalid, disp_rdata, pat(14 + j));
        end
      end else if (ram_en !== 1'b0 || disp_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL single_end en=%b rvalid=%b want 0/0", ram_en, disp_rvalid);
      end
    end
    checks++;
    if (nvalid != BURST) begin
      errors++;
      $display("FAIL single_count rvalid pulses=%0d want %0d", nvalid, BURST);
    end
    $display("test_single_disp done pulses=%0d", nvalid);
  endtask

  task automatic test_contention;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int wait_cyc;
    a = 19'h01234;
    d = 8'hA5;
    disp_req = 1'b1;
    host_wr_req = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    for (int r = 0; r < 2; r++) begin
      wait_cyc = 0;
      for (int i = 0; i < BURST; i++) begin
        tick();
        wait_cyc++;
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(16 + 16 * r + i) || host_wr_ack !== 1'b0) begin
          errors++;
          $display("FAIL cont_rd[%0d][%0d] en=%b we=%b addr=%0d ack=%b want 1/0/%0d/0", r, i, ram_en, ram_we, ram_addr, host_wr_ack, 16 + 16 * r + i);
        end
      end
      tick();
      wait_cyc++;
      checks++;
      if (ram_en !== 1'b0 || host_wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL cont_gap[%0d] en=%b ack=%b want 0/0", r, ram_en, host_wr_ack);
      end
      tick();
      wait_cyc++;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== a || ram_wdata !== d || host_wr_ack !== 1'b1) begin
        errors++;
        $display("FAIL cont_host[%0d] en=%b we=%b addr=%0h wdata=%0h ack=%b want 1/1/%0h/%0h/1", r, ram_en, ram_we, ram_addr, ram_wdata, host_wr_ack, a, d);
      end
      checks++;
      if (wait_cyc > BURST + 4) begin
        errors++;
        $display("FAIL cont_wait[%0d] waited=%0d want <=%0d", r, wait_cyc, BURST + 4);
      end
      $display("contention round %0d host waited %0d cycles", r, wait_cyc);
      if (r == 0) begin
        a = 19'h01235;
        d = 8'h5A;
        host_wr_addr = a;
        host_wr_data = d;
        tick();
        checks++;
        if (ram_en !== 1'b0 || host_wr_ack !== 1'b0) begin
          errors++;
          $display("FAIL cont_idle en=%b ack=%b want 0/0", ram_en, host_wr_ack);
        end
      end else begin
        host_wr_req = 1'b0;
        disp_req = 1'b0;
      end
    end
    tick();
    checks++;
    if (ram_en !== 1'b0 || host_wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL cont_release en=%b ack=%b want 0/0", ram_en, host_wr_ack);
    end
    settle(4);
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] datas [3];
    addrs[0] = 19'h01000; datas[0] = 8'h11;
    addrs[1] = 19'h01001; datas[1] = 8'h22;
    addrs[2] = 19'h01fff; datas[2] = 8'h33;
    host_wr_req = 1'b1;
    host_wr_addr = addrs[0];
    host_wr_data = datas[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== addrs[k] || ram_wdata !== datas[k] || host_wr_ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr[%0d] en=%b we=%b addr=%0h wdata=%0h ack=%b want 1/1/%0h/%0h/1", k, ram_en, ram_we, ram_addr, ram_wdata, host_wr_ack, addrs[k], datas[k]);
      end
      if (k < 2) begin
        host_wr_addr = addrs[k + 1];
        host_wr_data = datas[k + 1];
      end else begin
        host_wr_req = 1'b0;
      end
      tick();
      checks++;
      if (ram_en !== 1'b0 || host_wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap[%0d] en=%b ack=%b want 0/0", k, ram_en, host_wr_ack);
      end
      $display("host write %0d addr=%0h data=%0h", k, addrs[k], datas[k]);
    end
    settle(2);
  endtask

  task automatic test_wrap;
    int e;
    int ep;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    disp_req = 1'b1;
    tick();
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== '0) begin
      errors++;
      $display("FAIL wrap_rewind en=%b addr=%0d want 1/0", ram_en, ram_addr);
    end
    // 25 full bursts of 17 cycles each bring the pointer to 400.
    for (int k = 2; k <= 25 * 17; k++) tick();
    for (int i = 0; i < BURST; i++) begin
      tick();
      if (i == 0) disp_req = 1'b0;
      e = 400 + i;
      if (e >= FBW) e = e - FBW;
      checks++;
      if (ram_en !== 1'b1 || ram_addr !== ADDR_W'(e)) begin
        errors++;
        $display("FAIL wrap_rd[%0d] en=%b addr=%0d want 1/%0d", i, ram_en, ram_addr, e);
      end
      if (i >= 2) begin
        ep = 400 + i - 2;
        if (ep >= FBW) ep = ep - FBW;
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== pat(ep)) begin
          errors++;
          $display("FAIL wrap_data[%0d] rvalid=%b data=%0h want 1/%0h", i, disp_rvalid, disp_rdata, pat(ep));
        end
      end
    end
    $display("wrap burst done");
  endtask

  task automatic test_frame_start;
    tick();
    disp_req = 1'b1;
    for (int i = 0; i < BURST; i++) begin
      tick();
      if (i == 4) frame_start = 1'b1;
      if (i == 5) frame_start = 1'b0;
      checks++;
      if (ram_en !== 1'b1 || ram_addr !== ADDR_W'(8 + i)) begin
        errors++;
        $display("FAIL fs_mid_rd[%0d] en=%b addr=%0d want 1/%0d", i, ram_en, ram_addr, 8 + i);
      end
    end
    tick();
    checks++;
    if (ram_en !== 1'b0) begin
      errors++;
      $display("FAIL fs_gap ram_en=%b want 0", ram_en);
    end
    for (int i = 0; i < BURST; i++) begin
      tick();
      if (i == BURST - 1) frame_start = 1'b1;
      checks++;
      if (ram_en !== 1'b1 || ram_addr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL fs_rewound_rd[%0d] en=%b addr=%0d want 1/%0d", i, ram_en, ram_addr, i);
      end
    end
    tick();
    frame_start = 1'b0;
    checks++;
    if (ram_en !== 1'b0) begin
      errors++;
      $display("FAIL fs_gap2 ram_en=%b want 0", ram_en);
    end
    tick();
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== '0) begin
      errors++;
      $display("FAIL fs_last_rd en=%b addr=%0d want 1/0", ram_en, ram_addr);
    end
    disp_req = 1'b0;
    settle(20);
    $display("frame_start tests done");
  endtask

  task automatic test_reset_mid;
    disp_req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ram_en, ram_we, host_wr_ack, disp_rvalid} !== 4'b0000 || ram_addr !== '0 || ram_wdata !== '0 || disp_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_outs en/we/ack/rv=%b addr=%0h wdata=%0h rdata=%0h want all 0", {ram_en, ram_we, host_wr_ack, disp_rvalid}, ram_addr, ram_wdata, disp_rdata);
    end
    rst = 1'b0;
    disp_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      checks++;
      if (disp_rvalid !== 1'b0 || ram_en !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet[%0d] rvalid=%b en=%b want 0/0", j, disp_rvalid, ram_en);
      end
    end
    disp_req = 1'b1;
    tick();
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_ptr en=%b addr=%0d want 1/0", ram_en, ram_addr);
    end
    disp_req = 1'b0;
    settle(20);
    $display("reset mid-burst done");
  endtask

  initial begin
    test_reset();
    test_single_disp();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_frame_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
